// File: rtl/dfe_obs_pkg.sv
// dfe_obs_pkg: shared types, width helpers and stage indices for the DFE observation block.
package dfe_obs_pkg;
    typedef enum logic {IDLE, STREAM} rd_state_e;

    localparam int STG_FRAC  = 0;
    localparam int STG_IIR1  = 1;
    localparam int STG_IIR2  = 2;
    localparam int STG_IIR24 = 3;
    localparam int STG_CIC   = 4;

    function automatic int sel_width(input int n_stage);
        return $clog2(n_stage + 1);
    endfunction

    function automatic int tap_width(input int max_tap);
        return $clog2(max_tap + 1);
    endfunction
endpackage

// File: rtl/dfe_obs_mux_if.sv
// dfe_obs_mux_if: coefficient readback stream, one coefficient per valid/ready transfer.
interface dfe_obs_mux_if #(parameter int COEFF_WIDTH = 20) ();
    logic [COEFF_WIDTH-1:0] coeff_o;
    logic                   coeff_valid_o;
    logic                   coeff_ready_i;
    logic                   coeff_last_o;

    modport master (output coeff_o, coeff_valid_o, coeff_last_o, input coeff_ready_i);
    modport slave  (input coeff_o, coeff_valid_o, coeff_last_o, output coeff_ready_i);
endinterface

// File: rtl/dfe_coeff_reader.sv
// dfe_coeff_reader: streams one coefficient bank out over a valid/ready handshake.
module dfe_coeff_reader
    import dfe_obs_pkg::*;
#(
    parameter int N_STAGE     = 5,
    parameter int MAX_TAP     = 72,
    parameter int COEFF_WIDTH = 20,
    parameter int SEL_W       = 3,
    parameter int TAP_W       = 7
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [N_STAGE-1:0][MAX_TAP-1:0][COEFF_WIDTH-1:0]   coeff_i,
    input  logic [N_STAGE-1:0][TAP_W-1:0]                      stage_taps_i,
    input  logic                                               rd_req_i,
    input  logic [SEL_W-1:0]                                   rd_stage_i,
    output logic                                               rd_busy_o,
    output logic                                               rd_err_o,
    dfe_obs_mux_if.master                                      m
);
    rd_state_e        state_q;
    logic [SEL_W-1:0] stg_q, req_idx;
    logic [TAP_W-1:0] depth_q, idx_q, nxt, req_taps;
    logic             req_ok;

    assign req_idx  = rd_stage_i - SEL_W'(1);
    assign req_taps = stage_taps_i[req_idx];
    assign nxt      = idx_q + TAP_W'(1);
    assign req_ok   = rd_stage_i != '0 && rd_stage_i <= SEL_W'(N_STAGE) &&
                      req_taps != '0 && req_taps <= TAP_W'(MAX_TAP);

    // Outputs are registered so data and last stay frozen across a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            stg_q           <= '0;
            depth_q         <= '0;
            idx_q           <= '0;
            m.coeff_o       <= '0;
            m.coeff_valid_o <= 1'b0;
            m.coeff_last_o  <= 1'b0;
            rd_busy_o       <= 1'b0;
            rd_err_o        <= 1'b0;
        end else begin
            rd_err_o <= 1'b0;
            case (state_q)
                IDLE: if (rd_req_i) begin
                    if (req_ok) begin
                        state_q         <= STREAM;
                        stg_q           <= req_idx;
                        depth_q         <= req_taps;
                        idx_q           <= '0;
                        m.coeff_o       <= coeff_i[req_idx][0];
                        m.coeff_valid_o <= 1'b1;
                        m.coeff_last_o  <= req_taps == TAP_W'(1);
                        rd_busy_o       <= 1'b1;
                    end else begin
                        rd_err_o <= 1'b1;
                    end
                end
                STREAM: if (m.coeff_ready_i) begin
                    if (m.coeff_last_o) begin
                        state_q         <= IDLE;
                        m.coeff_o       <= '0;
                        m.coeff_valid_o <= 1'b0;
                        m.coeff_last_o  <= 1'b0;
                        rd_busy_o       <= 1'b0;
                    end else begin
                        idx_q          <= nxt;
                        m.coeff_o      <= coeff_i[stg_q][nxt];
                        m.coeff_last_o <= nxt == depth_q - TAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/dfe_obs_mux.sv
// dfe_obs_mux: registered stage tap, sample counter, sticky flags and coefficient readback.
module dfe_obs_mux
    import dfe_obs_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 20,
    parameter int N_STAGE     = 5,
    parameter int MAX_TAP     = 72,
    parameter int CNT_WIDTH   = 16,
    localparam int SEL_W      = sel_width(N_STAGE),
    localparam int TAP_W      = tap_width(MAX_TAP)
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [N_STAGE-1:0][DATA_WIDTH-1:0]                 stage_data_i,
    input  logic [N_STAGE-1:0]                                 stage_valid_i,
    input  logic [N_STAGE-1:0]                                 stage_ovf_i,
    input  logic [N_STAGE-1:0]                                 stage_unf_i,
    input  logic [SEL_W-1:0]                                   out_sel_i,
    input  logic                                               sel_update_i,
    input  logic [N_STAGE-1:0]                                 flag_clr_i,
    output logic [DATA_WIDTH-1:0]                              block_out_o,
    output logic                                               block_valid_o,
    output logic [CNT_WIDTH-1:0]                               sample_cnt_o,
    output logic [N_STAGE-1:0]                                 sticky_ovf_o,
    output logic [N_STAGE-1:0]                                 sticky_unf_o,
    output logic                                               any_ovf_o,
    output logic                                               any_unf_o,
    input  logic [N_STAGE-1:0][MAX_TAP-1:0][COEFF_WIDTH-1:0]   coeff_i,
    input  logic [N_STAGE-1:0][TAP_W-1:0]                      stage_taps_i,
    input  logic                                               rd_req_i,
    input  logic [SEL_W-1:0]                                   rd_stage_i,
    output logic                                               rd_busy_o,
    output logic                                               rd_err_o,
    dfe_obs_mux_if.master                                      coeff_if
);
    logic [SEL_W-1:0]      sel_q, sel_d, sel_idx;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [N_STAGE-1:0]    ovf_q, ovf_d, unf_q, unf_d;

    // A select update swallows the concurrent valid so no old-stage sample leaks out.
    always_comb begin
        sel_d   = sel_update_i ? (out_sel_i > SEL_W'(N_STAGE) ? '0 : out_sel_i) : sel_q;
        sel_idx = sel_q - SEL_W'(1);
        valid_d = !sel_update_i && sel_q != '0 && stage_valid_i[sel_idx];
        out_d   = sel_d == '0 ? '0 : valid_d ? stage_data_i[sel_idx] : out_q;
        cnt_d   = sel_update_i ? '0 : (valid_d && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        ovf_d   = stage_ovf_i | (ovf_q & ~flag_clr_i);
        unf_d   = stage_unf_i | (unf_q & ~flag_clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= '0;
            unf_q   <= '0;
        end else begin
            sel_q   <= sel_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign block_out_o   = out_q;
    assign block_valid_o = valid_q;
    assign sample_cnt_o  = cnt_q;
    assign sticky_ovf_o  = ovf_q;
    assign sticky_unf_o  = unf_q;
    assign any_ovf_o     = |ovf_q;
    assign any_unf_o     = |unf_q;

    dfe_coeff_reader #(
        .N_STAGE(N_STAGE), .MAX_TAP(MAX_TAP), .COEFF_WIDTH(COEFF_WIDTH),
        .SEL_W(SEL_W), .TAP_W(TAP_W)
    ) u_reader (
        .clk(clk), .rst_n(rst_n), .coeff_i(coeff_i), .stage_taps_i(stage_taps_i),
        .rd_req_i(rd_req_i), .rd_stage_i(rd_stage_i), .rd_busy_o(rd_busy_o),
        .rd_err_o(rd_err_o), .m(coeff_if)
    );
endmodule
